// File: rtl/adc_pkg.sv
// Shared definitions for the LTC2308 reader: FSM encoding, frame geometry
// and the fixed fields of the 6-bit configuration word.
package adc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONV  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } adc_state_e;

    localparam int FRAME_BITS = 12;
    localparam int CFG_BITS   = 6;

    localparam logic SD_SINGLE = 1'b1;
    localparam logic UNI       = 1'b1;
    localparam logic SLP       = 1'b0;

    // Field order on the wire: S/D, O/S, S1, S0, UNI, SLP (MSB first).
    function automatic logic [CFG_BITS-1:0] cfg_word(input logic [2:0] ch);
        return {SD_SINGLE, ch[0], ch[2], ch[1], UNI, SLP};
    endfunction

endpackage

// File: rtl/adc_sclk_gen.sv
// SCLK generator for one 12-bit LTC2308 frame: CLK_DIV prescaler, SCLK
// toggle register and bit counter, with rise/fall/last-bit strobes.
module adc_sclk_gen
    import adc_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic iClk,
    input  logic iRstN,
    input  logic iEn,
    output logic oSclk,
    output logic oRise,
    output logic oFall,
    output logic oLastBit
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [PW-1:0] presc_q, presc_d;
    logic          sclk_q, sclk_d;
    logic [3:0]    bit_q, bit_d;
    logic          tick;

    assign tick     = iEn && (presc_q == PW'(CLK_DIV - 1));
    assign oRise    = tick && !sclk_q;
    assign oFall    = tick && sclk_q;
    assign oLastBit = (bit_q == 4'(FRAME_BITS - 1));
    assign oSclk    = sclk_q;

    always_comb begin
        presc_d = presc_q;
        sclk_d  = sclk_q;
        bit_d   = bit_q;
        if (!iEn) begin
            // Outside SHIFT everything parks so the next frame starts with SCLK low.
            presc_d = '0;
            sclk_d  = 1'b0;
            bit_d   = '0;
        end else if (tick) begin
            presc_d = '0;
            sclk_d  = ~sclk_q;
            if (sclk_q) begin
                bit_d = oLastBit ? 4'd0 : bit_q + 4'd1;
            end
        end else begin
            presc_d = presc_q + 1'b1;
        end
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            presc_q <= '0;
            sclk_q  <= 1'b0;
            bit_q   <= '0;
        end else begin
            presc_q <= presc_d;
            sclk_q  <= sclk_d;
            bit_q   <= bit_d;
        end
    end

endmodule

// File: rtl/adc_ltc2308_reader.sv
// LTC2308 conversion sequencer: CONVST pulse, 12-bit SPI frame, one-cycle
// sample strobe. Optional ADC_CHAN_TAG_EN adds oChan, the sample's channel.
module adc_ltc2308_reader
    import adc_pkg::*;
#(
    parameter int CLK_DIV     = 2,
    parameter int CONV_CYCLES = 80
) (
    input  logic        iClk,
    input  logic        iRstN,
    input  logic        iStart,
    input  logic [2:0]  iChannel,
    input  logic        iSdo,
    output logic        oConvst,
    output logic        oSclk,
    output logic        oSdi,
    output logic [11:0] oData,
    output logic        oValid,
    output logic        oBusy,
`ifdef ADC_CHAN_TAG_EN
    output logic [2:0]  oChan,
`endif
    output logic [1:0]  oDbgState
);

    localparam int CW = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;

    adc_state_e                state_q, state_d;
    logic [CW-1:0]             conv_cnt_q, conv_cnt_d;
    logic [2:0]                ch_q, ch_d;
    logic [FRAME_BITS-1:0]     shreg_q, shreg_d;
    logic [FRAME_BITS-1:0]     data_q, data_d;
    logic [CFG_BITS-1:0]       cfg_sh_q, cfg_sh_d;
    logic                      sdi_q, sdi_d;
    logic [CFG_BITS-1:0]       cfg;
    logic                      sdo_s;
    logic                      sclk_rise, sclk_fall, last_bit;
    logic                      frame_end;

    // Fast SCLK leaves no room for synchroniser latency; board timing covers it.
    generate
        if (CLK_DIV >= 3) begin : g_sync
            logic [1:0] sync_q;
            always_ff @(posedge iClk or negedge iRstN) begin
                if (!iRstN) sync_q <= '0;
                else        sync_q <= {sync_q[0], iSdo};
            end
            assign sdo_s = sync_q[1];
        end else begin : g_direct
            assign sdo_s = iSdo;
        end
    endgenerate

    adc_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .iClk     (iClk),
        .iRstN    (iRstN),
        .iEn      (state_q == SHIFT),
        .oSclk    (oSclk),
        .oRise    (sclk_rise),
        .oFall    (sclk_fall),
        .oLastBit (last_bit)
    );

    assign cfg       = cfg_word(ch_q);
    assign frame_end = (state_q == SHIFT) && sclk_fall && last_bit;

    always_comb begin
        state_d    = state_q;
        conv_cnt_d = conv_cnt_q;
        ch_d       = ch_q;
        shreg_d    = shreg_q;
        data_d     = data_q;
        cfg_sh_d   = cfg_sh_q;
        sdi_d      = sdi_q;
        case (state_q)
            IDLE: begin
                if (iStart) begin
                    ch_d       = iChannel;
                    conv_cnt_d = '0;
                    state_d    = CONV;
                end
            end
            CONV: begin
                if (conv_cnt_q == CW'(CONV_CYCLES - 1)) begin
                    // First config bit must be on SDI before the first SCLK rise.
                    state_d  = SHIFT;
                    sdi_d    = cfg[CFG_BITS-1];
                    cfg_sh_d = {cfg[CFG_BITS-2:0], 1'b0};
                end else begin
                    conv_cnt_d = conv_cnt_q + 1'b1;
                end
            end
            SHIFT: begin
                if (sclk_rise) begin
                    shreg_d = {shreg_q[FRAME_BITS-2:0], sdo_s};
                end
                if (sclk_fall) begin
                    if (last_bit) begin
                        state_d = DONE;
                        data_d  = shreg_q;
                        sdi_d   = 1'b0;
                    end else begin
                        sdi_d    = cfg_sh_q[CFG_BITS-1];
                        cfg_sh_d = {cfg_sh_q[CFG_BITS-2:0], 1'b0};
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state_q    <= IDLE;
            conv_cnt_q <= '0;
            ch_q       <= '0;
            shreg_q    <= '0;
            data_q     <= '0;
            cfg_sh_q   <= '0;
            sdi_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            conv_cnt_q <= conv_cnt_d;
            ch_q       <= ch_d;
            shreg_q    <= shreg_d;
            data_q     <= data_d;
            cfg_sh_q   <= cfg_sh_d;
            sdi_q      <= sdi_d;
        end
    end

`ifdef ADC_CHAN_TAG_EN
    // The ADC returns the previous frame's channel, so the tag lags one frame.
    logic [2:0] prev_ch_q, tag_q;
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            prev_ch_q <= '0;
            tag_q     <= '0;
        end else if (frame_end) begin
            tag_q     <= prev_ch_q;
            prev_ch_q <= ch_q;
        end
    end
    assign oChan = tag_q;
`endif

    assign oConvst   = (state_q == CONV);
    assign oValid    = (state_q == DONE);
    assign oBusy     = (state_q != IDLE);
    assign oSdi      = sdi_q;
    assign oData     = data_q;
    assign oDbgState = state_q;

endmodule

// File: doc/adc_ltc2308_reader.md
# adc_ltc2308_reader

Front-end sampler driving the on-board LTC2308 12-bit SPI ADC. Issues a conversion on request, clocks out the configuration word and clocks in the 12-bit result. Delivers each sample as a one-cycle strobe, wired directly to the accumulator's clock-enable and 12-bit data inputs. The block is the accumulator's upstream source.

## Interface
Parameters:
- CLK_DIV, 2: system clocks per SCLK half-period (≥1).
- CONV_CYCLES, 80: clocks CONVST is held high for conversion (≥ tCONV, 1.6 µs at 50 MHz).

Ports:
- iClk  in  1  system clock; all logic on rising edge; the only clock.
- iRstN  in  1  reset, asynchronous assert, active-low.
- iStart  in  1  request one conversion; sampled only in IDLE.
- iChannel  in  3  single-ended channel 0–7; latched on accept.
- iSdo  in  1  ADC serial data out.
- oConvst  out  1  ADC CONVST.
- oSclk  out  1  ADC SCLK.
- oSdi  out  1  ADC serial data in (config word).
- oData  out  12  last received sample; holds until next oValid.
- oValid  out  1  one-cycle strobe, oData new this cycle.
- oBusy  out  1  high in every state except IDLE.

## Operation
- Reset values: oConvst=0, oSclk=0, oSdi=0, oData=0, oValid=0, oBusy=0, state IDLE.
- States: IDLE → CONV → SHIFT → DONE → IDLE.
- IDLE: on iStart=1, latch iChannel, go to CONV. Otherwise stay.
- CONV: oConvst=1 for exactly CONV_CYCLES clocks, then go to SHIFT with oConvst=0.
- SHIFT: 12 SCLK periods. oSclk starts low and toggles every CLK_DIV clocks, so SHIFT lasts 24·CLK_DIV clocks and ends with oSclk low.
- SHIFT, SDO sampling: iSdo is sampled, MSB first, in the clock where oSclk goes high.
- SHIFT, SDI drive: oSdi changes only with SCLK low. Bit k is driven from the start of SCLK period k.
- Config word, 6 bits, MSB first: S/D=1, O/S=ch[0], S1=ch[2], S0=ch[1], UNI=1, SLP=0. oSdi=0 for SCLK periods 7–12.
- DONE: one clock. oData ← shift register, oValid=1. Then IDLE.
- ADC pipelining: the result returned in a frame belongs to the channel configured in the previous frame. The first result after reset has undefined channel and must be discarded downstream.
- iStart while oBusy=1: ignored, never queued. iChannel changes after accept: no effect on the current frame.
- Reset mid-frame: outputs return to reset values immediately and the frame is abandoned. No oValid is issued.
- iSdo is synchronised by a 2-flop synchroniser only when CLK_DIV ≥ 3. Otherwise it is sampled directly (board-level timing closure).

## Timing
- Accept at cycle 0 (iStart=1 in IDLE).
- oConvst is high during cycles 1..CONV_CYCLES.
- SHIFT occupies cycles CONV_CYCLES+1 .. CONV_CYCLES+24·CLK_DIV.
- oValid rises at cycle 1+CONV_CYCLES+24·CLK_DIV; with the defaults, cycle 129.
- Minimum start-to-start period is 2+CONV_CYCLES+24·CLK_DIV clocks: DONE returns to IDLE, and IDLE accepts the next cycle.
- oValid is never high on two consecutive cycles.

## Configuration
- ADC_CHAN_TAG_EN defined: adds output oChan[2:0], the channel that oData belongs to. oChan equals the channel latched in the previous accepted frame and updates together with oData. oChan resets to 0.
- ADC_CHAN_TAG_EN undefined: no oChan port, no tag registers. All other behaviour is identical.

## Structure
- adc_pkg holds:
  - the state encoding (IDLE, CONV, SHIFT, DONE);
  - the config-word constants (SD_SINGLE=1, UNI=1, SLP=0);
  - the frame bit count, 12;
  - the config width, 6.
- Sub-module adc_sclk_gen: CLK_DIV prescaler plus 0..11 bit counter. It provides sclk, rise and fall strobes, and last_bit. The FSM and shift registers stay in the top module.

## Test plan
- Defaults; ADC model returns 12'hA5C; iStart pulse → oValid at cycle 129 with oData=12'hA5C; oConvst high for cycles 1–80; exactly 12 SCLK rises.
- iChannel=5 → oSdi sequence 1,1,1,0,1,0 captured on SCLK rises, then 0 for the remaining 6 bits.
- Frames on ch 3 then ch 6, with ADC_CHAN_TAG_EN → second oValid carries oChan=3, matching the model's pipelined data.
- iStart held high continuously → oValid exactly every 130 cycles; iStart pulses during SHIFT are ignored (no extra frames).
- iRstN low during SHIFT bit 5 → oSclk, oConvst, oBusy drop asynchronously; no oValid; the next iStart runs a clean full frame.
- CLK_DIV=1, CONV_CYCLES=3 → oValid at cycle 28; SCLK toggles every clock; data correct.
